i2c_reg_sequencer: RTL and testbench



---
 rtl/i2c_reg_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_reg_sequencer
//
// Front end for the byte-level I2C engine. It takes one register-access
// request and runs the whole bus sequence: START, address and data bytes,
// repeated START for reads, and STOP. Each engine operation has a timeout.
//
//   write : START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP
//   read  : START, WRITE {dev,0}, WRITE reg, START, WRITE {dev,1}, READ, STOP
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake (accepted on valid && ready)
//   req_rnw_i              1 = read, 0 = write
//   req_dev_addr_i         7-bit slave address
//   req_reg_addr_i         register address
//   req_wdata_i            write data (ignored for reads)
//   rsp_valid_o            one-cycle pulse at the end of a transaction
//   rsp_rdata_o            read data, updated only by successful reads
//   rsp_error_o            1 = transaction aborted by timeout
//   busy_o                 high from accept through the response cycle
//   i2c_instruction_o      to engine: 00 start, 01 stop, 10 read, 11 write
//   i2c_enable_o           to engine enable
//   i2c_byte_o             to engine byte_to_send
//   i2c_byte_i             from engine byte_received
//   i2c_complete_i         from engine complete
// ----------------------------------------------------------------------------
module i2c_reg_sequencer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rnw_i,
   input  logic [6:0] req_dev_addr_i,
   input  logic [7:0] req_reg_addr_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_error_o,
   output logic       busy_o,
   output logic [1:0] i2c_instruction_o,
   output logic       i2c_enable_o,
   output logic [7:0] i2c_byte_o,
   input  logic [7:0] i2c_byte_i,
   input  logic       i2c_complete_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] INSTR_START = 2'b00;
   localparam logic [1:0] INSTR_STOP  = 2'b01;
   localparam logic [1:0] INSTR_READ  = 2'b10;
   localparam logic [1:0] INSTR_WRITE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DROP,
      ST_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic [TW-1:0] tmo_q, tmo_d;

   // request fields and read holding register (data path, no reset)
   logic          rnw_q, rnw_d;
   logic [6:0]    dev_q, dev_d;
   logic [7:0]    reg_q, reg_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    hold_q, hold_d;

   // registered outputs
   logic          ready_q, ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic          rsp_error_q, rsp_error_d;
   logic          busy_q, busy_d;
   logic [1:0]    instr_q, instr_d;
   logic          en_q, en_d;
   logic [7:0]    byte_q, byte_d;

   logic [2:0]    last_step;

   // Instruction and byte for a given step of the sequence: {instr, byte}.
   function automatic logic [9:0] step_op(input logic [2:0] step,
                                          input logic       rnw,
                                          input logic [6:0] dev,
                                          input logic [7:0] rega,
                                          input logic [7:0] wdata);
      logic [9:0] op;
      op = {INSTR_STOP, 8'h00};
      if (rnw) begin
         case (step)
            3'd0:    op = {INSTR_START, 8'h00};
            3'd1:    op = {INSTR_WRITE, dev, 1'b0};
            3'd2:    op = {INSTR_WRITE, rega};
            3'd3:    op = {INSTR_START, 8'h00};
            3'd4:    op = {INSTR_WRITE, dev, 1'b1};
            3'd5:    op = {INSTR_READ, 8'h00};
            default: op = {INSTR_STOP, 8'h00};
         endcase
      end else begin
         case (step)
            3'd0:    op = {INSTR_START, 8'h00};
            3'd1:    op = {INSTR_WRITE, dev, 1'b0};
            3'd2:    op = {INSTR_WRITE, rega};
            3'd3:    op = {INSTR_WRITE, wdata};
            default: op = {INSTR_STOP, 8'h00};
         endcase
      end
      return op;
   endfunction

   assign last_step = rnw_q ? 3'd6 : 3'd4;

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      tmo_d       = tmo_q;
      rnw_d       = rnw_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      hold_d      = hold_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      busy_d      = busy_q;
      instr_d     = instr_q;
      en_d        = en_q;
      byte_d      = byte_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               rnw_d             = req_rnw_i;
               dev_d             = req_dev_addr_i;
               reg_d             = req_reg_addr_i;
               wdata_d           = req_wdata_i;
               step_d            = 3'd0;
               {instr_d, byte_d} = step_op(3'd0, req_rnw_i, req_dev_addr_i,
                                           req_reg_addr_i, req_wdata_i);
               en_d              = 1'b1;
               tmo_d             = '0;
               ready_d           = 1'b0;
               busy_d            = 1'b1;
               rsp_error_d       = 1'b0;
               state_d           = ST_ARM;
            end
         end

         // The engine still shows complete from the previous operation until
         // it takes the new enable; a low complete means it has accepted.
         ST_ARM: begin
            tmo_d = tmo_q + TW'(1);
            if (!i2c_complete_i) begin
               state_d = ST_RUN;
            end else if (tmo_q == TMO_LAST) begin
               en_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               state_d     = ST_RESP;
            end
         end

         ST_RUN: begin
            tmo_d = tmo_q + TW'(1);
            if (i2c_complete_i) begin
               en_d = 1'b0;
               if (instr_q == INSTR_READ) begin
                  hold_d = i2c_byte_i;
               end
               state_d = ST_DROP;
            end else if (tmo_q == TMO_LAST) begin
               en_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               state_d     = ST_RESP;
            end
         end

         // Enable is low for exactly this one cycle between operations.
         ST_DROP: begin
            if (step_q == last_step) begin
               rsp_valid_d = 1'b1;
               if (rnw_q) begin
                  rsp_rdata_d = hold_q;
               end
               state_d = ST_RESP;
            end else begin
               step_d            = step_q + 3'd1;
               {instr_d, byte_d} = step_op(step_q + 3'd1, rnw_q, dev_q,
                                           reg_q, wdata_q);
               en_d              = 1'b1;
               tmo_d             = '0;
               state_d           = ST_ARM;
            end
         end

         ST_RESP: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         step_q      <= 3'd0;
         tmo_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_error_q <= 1'b0;
         busy_q      <= 1'b0;
         instr_q     <= 2'b00;
         en_q        <= 1'b0;
         byte_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         tmo_q       <= tmo_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
         busy_q      <= busy_d;
         instr_q     <= instr_d;
         en_q        <= en_d;
         byte_q      <= byte_d;
      end
   end

   always_ff @(posedge clk_i) begin
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
   end

   assign req_ready_o       = ready_q;
   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_rdata_o       = rsp_rdata_q;
   assign rsp_error_o       = rsp_error_q;
   assign busy_o            = busy_q;
   assign i2c_instruction_o = instr_q;
   assign i2c_enable_o      = en_q;
   assign i2c_byte_o        = byte_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//
// Two sequencer instances: one with the default timeout for normal traffic and
// one with a short timeout for the abort case. A shared behavioural engine
// model answers whichever instance is selected; the expected bus operation
// list is built from the register-access rules and compared with what the
// engine model receives.
// ----------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

   localparam int T_SHORT = 64;

   logic       clk;
   logic       rst_n;
   logic       sel;

   logic       req_valid;
   logic       req_rnw;
   logic [6:0] req_dev;
   logic [7:0] req_reg;
   logic [7:0] req_wdata;
   logic       cpl;
   logic [7:0] eng_byte;

   logic       a_ready, a_rsp_valid, a_err, a_busy, a_en;
   logic [7:0] a_rdata, a_byte;
   logic [1:0] a_instr;
   logic       t_ready, t_rsp_valid, t_err, t_busy, t_en;
   logic [7:0] t_rdata, t_byte;
   logic [1:0] t_instr;

   logic       ready, rsp_valid, err, busy, en;
   logic [7:0] rdata, byte_o;
   logic [1:0] instr;

   int total;
   int bad;

   i2c_reg_sequencer u_dut_a (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_valid_i       (req_valid && !sel),
      .req_ready_o       (a_ready),
      .req_rnw_i         (req_rnw),
      .req_dev_addr_i    (req_dev),
      .req_reg_addr_i    (req_reg),
      .req_wdata_i       (req_wdata),
      .rsp_valid_o       (a_rsp_valid),
      .rsp_rdata_o       (a_rdata),
      .rsp_error_o       (a_err),
      .busy_o            (a_busy),
      .i2c_instruction_o (a_instr),
      .i2c_enable_o      (a_en),
      .i2c_byte_o        (a_byte),
      .i2c_byte_i        (eng_byte),
      .i2c_complete_i    (cpl)
   );

   i2c_reg_sequencer #(.TIMEOUT_CYCLES(T_SHORT)) u_dut_t (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .req_valid_i       (req_valid && sel),
      .req_ready_o       (t_ready),
      .req_rnw_i         (req_rnw),
      .req_dev_addr_i    (req_dev),
      .req_reg_addr_i    (req_reg),
      .req_wdata_i       (req_wdata),
      .rsp_valid_o       (t_rsp_valid),
      .rsp_rdata_o       (t_rdata),
      .rsp_error_o       (t_err),
      .busy_o            (t_busy),
      .i2c_instruction_o (t_instr),
      .i2c_enable_o      (t_en),
      .i2c_byte_o        (t_byte),
      .i2c_byte_i        (eng_byte),
      .i2c_complete_i    (cpl)
   );

   assign ready     = sel ? t_ready     : a_ready;
   assign rsp_valid = sel ? t_rsp_valid : a_rsp_valid;
   assign err       = sel ? t_err       : a_err;
   assign busy      = sel ? t_busy      : a_busy;
   assign en        = sel ? t_en        : a_en;
   assign rdata     = sel ? t_rdata     : a_rdata;
   assign byte_o    = sel ? t_byte      : a_byte;
   assign instr     = sel ? t_instr     : a_instr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // engine model configuration and state
   int         lat_cfg, stale_cfg, hang_op, op_idx, stale_left, cnt;
   logic [7:0] rd_byte_cfg;
   bit         eng_busy, need_low, hanging, skip_fall, en_prev;
   logic [1:0] cur_instr;
   int         cyc, low_run, rise_cyc;
   logic [9:0] op_q[$];
   int         low_q[$];
   logic [9:0] exp_q[$];
   logic [7:0] exp_rdata[2];

   // Monitor then engine model, both on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (en && !en_prev) begin
            low_q.push_back(low_run);
            rise_cyc = cyc;
         end
         if (!en && en_prev && !skip_fall) chk("en_fall_needs_cpl", cpl, 1);
         if (!en) low_run++;
         else low_run = 0;
         en_prev = en;

         if (!rst_n) begin
            eng_busy = 0; need_low = 0; cpl = 1'b1; stale_left = stale_cfg;
         end else if (!eng_busy) begin
            if (!en) need_low = 0;
            else if (!need_low) begin
               if (stale_left > 0) stale_left--;
               else begin
                  cpl = 1'b0; eng_busy = 1; cnt = lat_cfg;
                  hanging = (op_idx == hang_op);
                  cur_instr = instr;
                  op_q.push_back({instr, byte_o});
                  op_idx++;
               end
            end
         end else if (!en) begin
            eng_busy = 0; need_low = 0; cpl = 1'b1;
         end else if (!hanging) begin
            if (cnt > 1) cnt--;
            else begin
               cpl = 1'b1;
               if (cur_instr == 2'b10) eng_byte = rd_byte_cfg;
               eng_busy = 0; need_low = 1; stale_left = stale_cfg;
            end
         end
      end
   end

   // Expected bus operations for one register access.
   task automatic add_ops(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
      exp_q.push_back({2'b00, 8'h00});
      exp_q.push_back({2'b11, dev, 1'b0});
      exp_q.push_back({2'b11, rg});
      if (rnw) begin
         exp_q.push_back({2'b00, 8'h00});
         exp_q.push_back({2'b11, dev, 1'b1});
         exp_q.push_back({2'b10, 8'h00});
      end else begin
         exp_q.push_back({2'b11, wd});
      end
      exp_q.push_back({2'b01, 8'h00});
   endtask

   task automatic setup_engine(input int lat, input int stale, input int hang, input logic [7:0] rb);
      lat_cfg = lat; stale_cfg = stale; stale_left = stale; hang_op = hang;
      rd_byte_cfg = rb; op_idx = 0;
      op_q.delete(); low_q.delete(); exp_q.delete();
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (!rsp_valid && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      chk({tag, "_rsp_seen"}, rsp_valid, 1);
   endtask

   task automatic check_ops(input string tag, input int nexp);
      chk({tag, "_nops"}, op_q.size(), nexp);
      for (int k = 0; k < nexp && k < op_q.size(); k++)
         chk({tag, "_op"}, op_q[k], exp_q[k]);
   endtask

   task automatic do_txn(input string tag, input bit rnw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rb,
                         input int lat, input int stale, input int hang, input bit exp_err);
      setup_engine(lat, stale, hang, rb);
      add_ops(rnw, dev, rg, wd);
      skip_fall = exp_err;
      chk({tag, "_ready"}, ready, 1);
      req_valid = 1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
      @(negedge clk); #1;
      req_valid = 0;
      chk({tag, "_accept"}, {ready, busy, en}, 3'b011);
      wait_rsp(tag);
      if (rsp_valid) begin
         if (rnw && !exp_err) exp_rdata[sel] = rb;
         chk({tag, "_err"}, err, exp_err);
         chk({tag, "_rdata"}, rdata, exp_rdata[sel]);
         chk({tag, "_busy_en"}, {busy, en}, 2'b10);
         if (exp_err) chk({tag, "_tmo_cycles"}, cyc - rise_cyc, T_SHORT);
      end
      @(negedge clk); #1;
      chk({tag, "_idle"}, {ready, busy, rsp_valid, en}, 4'b1000);
      if (exp_err) begin
         check_ops(tag, hang + 1);
      end else begin
         check_ops(tag, exp_q.size());
         for (int k = 1; k < low_q.size(); k++) chk({tag, "_gap"}, low_q[k], 1);
      end
      skip_fall = 0;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; low_run = 0; rise_cyc = 0; en_prev = 0;
      sel = 0; rst_n = 0; req_valid = 0; req_rnw = 0; req_dev = '0; req_reg = '0;
      req_wdata = '0; cpl = 1'b1; eng_byte = 8'h00; skip_fall = 0;
      eng_busy = 0; need_low = 0; hanging = 0; cnt = 0; cur_instr = 2'b00;
      exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
      setup_engine(1, 0, -1, 8'h00);
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {ready, busy, rsp_valid, err, en, instr, byte_o, rdata}, {1'b1, 22'd0});
      rst_n = 1;
      @(negedge clk); #1;

      do_txn("wr_3c", 1'b0, 7'h3C, 8'h00, 8'hAF, 8'h00, 130, 0, -1, 1'b0);
      do_txn("rd_68", 1'b1, 7'h68, 8'h75, 8'h00, 8'h71, 130, 0, -1, 1'b0);
      do_txn("stale", 1'b0, 7'h21, 8'h10, 8'h5A, 8'h00, 10, 5, -1, 1'b0);

      sel = 1;
      @(negedge clk); #1;
      do_txn("tmo", 1'b0, 7'h12, 8'h34, 8'h56, 8'h00, 8, 0, 2, 1'b1);
      sel = 0;
      @(negedge clk); #1;

      // back-to-back: write then read with valid held high
      setup_engine(20, 0, -1, 8'hC3);
      add_ops(1'b0, 7'h50, 8'h0A, 8'h99);
      add_ops(1'b1, 7'h2B, 8'hE0, 8'h00);
      req_valid = 1; req_rnw = 0; req_dev = 7'h50; req_reg = 8'h0A; req_wdata = 8'h99;
      @(negedge clk); #1;
      req_rnw = 1; req_dev = 7'h2B; req_reg = 8'hE0; req_wdata = 8'h00;
      wait_rsp("b2b_first");
      chk("b2b_first_err", err, 0);
      chk("b2b_first_rdata", rdata, exp_rdata[0]);
      @(negedge clk); #1;
      chk("b2b_ready_after_rsp", {ready, busy}, 2'b10);
      @(negedge clk); #1;
      chk("b2b_second_accept", {ready, busy, en}, 3'b011);
      req_valid = 0;
      wait_rsp("b2b_second");
      exp_rdata[0] = 8'hC3;
      chk("b2b_second_err", err, 0);
      chk("b2b_second_rdata", rdata, exp_rdata[0]);
      @(negedge clk); #1;
      chk("b2b_idle", {ready, busy, rsp_valid, en}, 4'b1000);
      check_ops("b2b", exp_q.size());
      for (int k = 1; k < low_q.size(); k++)
         if (k != 5) chk("b2b_gap", low_q[k], 1);

      // randomized traffic
      for (int i = 0; i < 8; i++) begin
         do_txn("rand", 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), $urandom_range(1, 20), $urandom_range(0, 3), -1, 1'b0);
      end

      // reset during the RUN phase of the READ step
      setup_engine(130, 0, -1, 8'h44);
      req_valid = 1; req_rnw = 1; req_dev = 7'h68; req_reg = 8'h3B; req_wdata = 8'h00;
      @(negedge clk); #1;
      req_valid = 0;
      for (int n = 0; n < 3000 && op_q.size() < 6; n++) begin
         @(negedge clk); #1;
      end
      chk("rst_reached_read", op_q.size(), 6);
      repeat (20) @(negedge clk);
      skip_fall = 1;
      #2 rst_n = 0;
      #1;
      chk("rst_async_outputs", {ready, busy, rsp_valid, err, en, instr, byte_o, rdata}, {1'b1, 22'd0});
      begin
         logic seen;
         seen = 0;
         repeat (3) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
         end
         chk("rst_no_rsp", seen, 0);
      end
      rst_n = 1;
      exp_rdata[0] = 8'h00;
      @(negedge clk); #1;
      skip_fall = 0;
      do_txn("post_rst", 1'b0, 7'h3C, 8'h01, 8'h7E, 8'h00, 12, 0, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
